// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Grants bursts of up to BURST_LEN words and never writes while the FIFO is full.
module fifo_wr_arbiter #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned BURST_LEN  = 4,
   parameter int unsigned ID_WIDTH   = $clog2(NUM_REQ)
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [NUM_REQ-1:0]            req_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] data_i,
   output logic [NUM_REQ-1:0]            ack_o,
   input  logic                          fifo_full_i,
   output logic                          fifo_wr_en_o,
   output logic [DATA_WIDTH-1:0]         fifo_wr_data_o,
   output logic [ID_WIDTH-1:0]           owner_o,
   output logic                          busy_o
);

   localparam int unsigned BEAT_WIDTH = $clog2(BURST_LEN) + 1;
   localparam logic [BEAT_WIDTH-1:0] LAST_BEAT = BEAT_WIDTH'(BURST_LEN - 1);
   localparam logic [ID_WIDTH-1:0]   LAST_ID   = ID_WIDTH'(NUM_REQ - 1);

   typedef enum logic {
      ST_IDLE,
      ST_GRANT
   } state_e;

   state_e                  state_q, state_d;
   logic [ID_WIDTH-1:0]     owner_q, owner_d;
   logic [ID_WIDTH-1:0]     rr_last_q, rr_last_d;
   logic [BEAT_WIDTH-1:0]   beat_cnt_q, beat_cnt_d;

   logic                    owner_req;
   logic                    wr_en;
   logic                    burst_done;
   logic                    release_grant;

   // Search starts one past 'last' and wraps, so 'last' itself is considered last.
   function automatic logic [ID_WIDTH-1:0] rr_pick(
      input logic [NUM_REQ-1:0]  req,
      input logic [ID_WIDTH-1:0] last
   );
      logic [ID_WIDTH-1:0] pick;
      logic                found;
      int unsigned         idx;
      pick  = '0;
      found = 1'b0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         idx = (32'(last) + k) % NUM_REQ;
         if (!found && req[idx]) begin
            pick  = ID_WIDTH'(idx);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         owner_q    <= '0;
         rr_last_q  <= LAST_ID;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         rr_last_q  <= rr_last_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   always_comb begin
      owner_req      = 1'b0;
      fifo_wr_data_o = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (owner_q == ID_WIDTH'(i)) begin
            owner_req      = req_i[i];
            fifo_wr_data_o = data_i[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end

      busy_o = (state_q == ST_GRANT);
      // Gating with rst_i keeps an abandoned burst from writing during the reset cycle.
      wr_en  = busy_o && owner_req && !fifo_full_i && !rst_i;

      fifo_wr_en_o = wr_en;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         ack_o[i] = wr_en && (owner_q == ID_WIDTH'(i));
      end

      burst_done    = wr_en && (beat_cnt_q == LAST_BEAT);
      release_grant = busy_o && (burst_done || !owner_req);

      state_d    = state_q;
      owner_d    = owner_q;
      rr_last_d  = rr_last_q;
      beat_cnt_d = beat_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (|req_i) begin
               owner_d    = rr_pick(req_i, rr_last_q);
               beat_cnt_d = '0;
               state_d    = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (release_grant) begin
               rr_last_d = owner_q;
               if (|req_i) begin
                  owner_d    = rr_pick(req_i, owner_q);
                  beat_cnt_d = '0;
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (wr_en) begin
               beat_cnt_d = beat_cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign owner_o = owner_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed scenarios push expected writes,
// a negedge monitor pops and compares every FIFO write.
module tb_fifo_wr_arbiter;

   localparam int NR = 4;
   localparam int DW = 8;
   localparam int BL = 4;
   localparam int IW = 2;

   logic              clk = 1'b0;
   logic              rst_i;
   logic [NR-1:0]     req_i;
   logic [NR*DW-1:0]  data_i;
   logic [NR-1:0]     ack_o;
   logic              fifo_full_i;
   logic              fifo_wr_en_o;
   logic [DW-1:0]     fifo_wr_data_o;
   logic [IW-1:0]     owner_o;
   logic              busy_o;

   always #5 clk = ~clk;

   fifo_wr_arbiter #(
      .NUM_REQ   (NR),
      .DATA_WIDTH(DW),
      .BURST_LEN (BL)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .req_i         (req_i),
      .data_i        (data_i),
      .ack_o         (ack_o),
      .fifo_full_i   (fifo_full_i),
      .fifo_wr_en_o  (fifo_wr_en_o),
      .fifo_wr_data_o(fifo_wr_data_o),
      .owner_o       (owner_o),
      .busy_o        (busy_o)
   );

   typedef struct packed {
      logic [IW-1:0] owner;
      logic [DW-1:0] data;
   } exp_t;

   exp_t          exp_q[$];
   exp_t          mon_e;
   int            n_cmp = 0;
   int            n_err = 0;
   int            rem[NR];
   int            cnt[NR];
   logic [DW-1:0] base[NR];
   logic [NR-1:0] ack_seen = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
      end
   endtask

   task automatic push(input int o, input int d);
      exp_t e;
      e.owner = IW'(o);
      e.data  = DW'(d);
      exp_q.push_back(e);
   endtask

   // Producers present base+count and request while words remain.
   task automatic drive();
      for (int i = 0; i < NR; i++) begin
         req_i[i]            = (rem[i] > 0);
         data_i[i*DW +: DW]  = base[i] + DW'(cnt[i]);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
         if (ack_seen[i]) begin
            cnt[i]++;
            if (rem[i] > 0) rem[i]--;
         end
      end
      drive();
      #1;
   endtask

   task automatic do_reset();
      rst_i       = 1'b1;
      fifo_full_i = 1'b0;
      for (int i = 0; i < NR; i++) begin
         rem[i] = 0;
         cnt[i] = 0;
      end
      drive();
      repeat (2) cycle();
      rst_i = 1'b0;
      #1;
   endtask

   task automatic drain(input string name, input int budget);
      for (int c = 0; c < budget; c++) begin
         if (exp_q.size() == 0 && !busy_o) break;
         cycle();
      end
      chk({name, "_queue_left"}, exp_q.size(), 0);
      chk({name, "_idle"}, busy_o, 0);
   endtask

   always @(negedge clk) begin
      ack_seen = ack_o;
      if (fifo_full_i === 1'b1) chk("wr_while_full", fifo_wr_en_o, 0);
      if (fifo_wr_en_o === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_write", fifo_wr_en_o, 0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("wr_owner", owner_o, mon_e.owner);
            chk("wr_data", fifo_wr_data_o, mon_e.data);
            chk("wr_ack", ack_o, 32'd1 << mon_e.owner);
         end
      end else if (ack_o !== '0) begin
         chk("ack_without_wr", ack_o, 0);
      end
   end

   initial begin
      int total, mx, mn;
      rst_i       = 1'b1;
      fifo_full_i = 1'b0;
      req_i       = '0;
      data_i      = '0;
      for (int i = 0; i < NR; i++) begin
         rem[i]  = 0;
         cnt[i]  = 0;
         base[i] = DW'(8'h10 * (i + 1));
      end

      // 1: lone requester 1, continuous writes with re-grant every 4 words
      do_reset();
      chk("rst_busy", busy_o, 0);
      chk("rst_owner", owner_o, 0);
      chk("rst_wr_en", fifo_wr_en_o, 0);
      chk("rst_ack", ack_o, 0);
      base[1] = 8'hA0;
      rem[1]  = 8;
      drive();
      #1;
      for (int k = 0; k < 8; k++) push(1, 8'hA0 + k);
      chk("t1_cycle0_idle", busy_o, 0);
      chk("t1_cycle0_no_wr", fifo_wr_en_o, 0);
      for (int c = 1; c <= 8; c++) begin
         cycle();
         chk("t1_owner", owner_o, 1);
         chk("t1_continuous_wr", fifo_wr_en_o, 1);
      end
      drain("t1", 20);

      // 2: all four requesting, 4-word bursts in order 0,1,2,3
      do_reset();
      for (int i = 0; i < NR; i++) begin
         base[i] = DW'(8'h10 * (i + 1));
         rem[i]  = 8;
      end
      drive();
      #1;
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < NR; i++)
            for (int k = 0; k < BL; k++) push(i, 8'h10 * (i + 1) + r * 4 + k);
      for (int c = 1; c <= 16; c++) begin
         cycle();
         chk("t2_wr_every_cycle", fifo_wr_en_o, 1);
         chk("t2_owner_order", owner_o, (c - 1) / 4);
      end
      cycle();
      chk("t2_cycle17_owner", owner_o, 0);
      drain("t2", 40);

      // 3: owner 2 stalled at beat 1 for three cycles
      do_reset();
      rem[2] = 8;
      rem[3] = 4;
      drive();
      #1;
      for (int k = 0; k < 4; k++) push(2, 8'h30 + k);
      for (int k = 0; k < 4; k++) push(3, 8'h40 + k);
      for (int k = 4; k < 8; k++) push(2, 8'h30 + k);
      cycle();
      chk("t3_first_owner", owner_o, 2);
      for (int c = 2; c <= 4; c++) begin
         cycle();
         fifo_full_i = 1'b1;
         #1;
         chk("t3_stall_no_wr", fifo_wr_en_o, 0);
         chk("t3_stall_no_ack", ack_o, 0);
         chk("t3_stall_owner", owner_o, 2);
      end
      cycle();
      fifo_full_i = 1'b0;
      #1;
      cycle();
      cycle();
      chk("t3_last_beat_owner", owner_o, 2);
      cycle();
      chk("t3_release_to_3", owner_o, 3);
      drain("t3", 40);

      // 4: owner 2 withdraws after two words, 3 takes over
      do_reset();
      rem[2] = 2;
      rem[3] = 3;
      drive();
      #1;
      push(2, 8'h30);
      push(2, 8'h31);
      for (int k = 0; k < 3; k++) push(3, 8'h40 + k);
      repeat (3) cycle();
      chk("t4_drop_no_wr", fifo_wr_en_o, 0);
      chk("t4_drop_owner", owner_o, 2);
      cycle();
      chk("t4_next_owner", owner_o, 3);
      chk("t4_next_wr", fifo_wr_en_o, 1);
      repeat (3) cycle();
      chk("t4_withdraw_no_wr", fifo_wr_en_o, 0);
      cycle();
      chk("t4_idle_after", busy_o, 0);
      drain("t4", 10);

      // 5: reset during owner 1 beat 2, then requests from 0 and 3
      do_reset();
      rem[1] = 8;
      drive();
      #1;
      push(1, 8'h20);
      push(1, 8'h21);
      for (int k = 0; k < 4; k++) push(0, 8'h10 + k);
      for (int k = 0; k < 4; k++) push(3, 8'h40 + k);
      repeat (3) cycle();
      rst_i  = 1'b1;
      rem[1] = 0;
      rem[0] = 4;
      rem[3] = 4;
      drive();
      #1;
      chk("t5_reset_no_wr", fifo_wr_en_o, 0);
      cycle();
      rst_i = 1'b0;
      #1;
      chk("t5_after_reset_idle", busy_o, 0);
      cycle();
      chk("t5_owner0", owner_o, 0);
      repeat (4) cycle();
      chk("t5_owner3", owner_o, 3);
      drain("t5", 30);

      // 6: saturated load, full flag toggling every other cycle
      do_reset();
      for (int i = 0; i < NR; i++) begin
         base[i] = DW'(8'h40 * i);
         rem[i]  = 1000;
      end
      drive();
      #1;
      for (int n = 0; n < 120; n++)
         push((n / 4) % 4, 8'h40 * ((n / 4) % 4) + (n / 16) * 4 + n % 4);
      for (int c = 0; c < 200; c++) begin
         fifo_full_i = (c % 2 == 1);
         #1;
         cycle();
      end
      fifo_full_i = 1'b0;
      for (int i = 0; i < NR; i++) rem[i] = 0;
      drive();
      for (int c = 0; c < 10 && busy_o; c++) cycle();
      chk("t6_idle", busy_o, 0);
      total = 0;
      mx    = cnt[0];
      mn    = cnt[0];
      for (int i = 0; i < NR; i++) begin
         total += cnt[i];
         if (cnt[i] > mx) mx = cnt[i];
         if (cnt[i] < mn) mn = cnt[i];
      end
      chk("t6_fair_spread_le_burst", (mx - mn) <= BL, 1);
      chk("t6_total_writes_ge_90", total >= 90, 1);
      exp_q.delete();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
